serial_frame_tx: RTL

- Parallel-in, serial-out framed transmitter; it is the sending end of the single-bit serial links that feed our shift-register receivers.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Emits it on dout as: start bit (0), data bits LSB first, optional even parity, stop bit (1).
- Each serial bit is held for CLKS_PER_BIT clocks.

---
 rtl/serial_frame_tx_if.sv | 11 +
 rtl/serial_frame_tx.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx_if.sv
// Word handshake between a producer and the serial frame transmitter.
interface serial_frame_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, data LSB first, optional even parity,
// stop bit, each bit held for CLKS_PER_BIT clocks. A new word may be accepted
// in the last clock of the stop bit so that consecutive frames abut.
module serial_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             reset,
  serial_frame_tx_if.slave tx_if,
  output logic             dout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             parity_q, parity_d;
  logic             dout_q, dout_d;
  logic             last_clk;
  logic             accept;

  // Handshake and status outputs are decoded straight from the current state.
  always_comb begin
    last_clk        = (cnt_q == LAST_CNT);
    tx_if.din_ready = (state_q == IDLE) || ((state_q == STOP) && last_clk);
    accept          = tx_if.din_valid && tx_if.din_ready;
    busy            = (state_q != IDLE);
    done            = (state_q == STOP) && last_clk;
    dout            = dout_q;
  end

  // Next-state logic; the line level is derived from the state being entered so dout is a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    parity_d  = parity_q;
    dout_d    = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          cnt_d     = '0;
          bit_idx_d = '0;
          shreg_d   = tx_if.din;
          parity_d  = ^tx_if.din;
        end
      end
      START: begin
        if (last_clk) begin
          state_d   = DATA;
          cnt_d     = '0;
          bit_idx_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (last_clk) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (last_clk) begin
          state_d = STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (last_clk) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          if (accept) begin
            state_d  = START;
            shreg_d  = tx_if.din;
            parity_d = ^tx_if.din;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      START:   dout_d = 1'b0;
      DATA:    dout_d = shreg_d[0];
      PARITY:  dout_d = parity_d;
      default: dout_d = 1'b1;
    endcase
  end

  // State register; reset aborts any frame and returns the line to idle-high at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      parity_q  <= 1'b0;
      dout_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      parity_q  <= parity_d;
      dout_q    <= dout_d;
    end
  end

endmodule
